// File: rtl/unified_mem_responder.sv
// unified_mem_responder
//   Memory-side responder for the pipelined core. One shared word array serves
//   the instruction port (registered IR), the data port (registered D_IN, with
//   write-through on simultaneous read+write) and a valid/ready preload port.
//   After reset the array is zeroed one word per cycle (CLEAR), then the block
//   serves requests (RUN).
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   I_ADDR, im_oen, IR      instruction fetch: address, read enable (low), data
//   D_ADDR, dm_oen, dm_wen  data access: address, read enable (low), write enable (low)
//   D_OUT, D_IN             data write data from core, read data to core
//   ld_valid, ld_addr,
//   ld_data, ld_ready       preload write request / acceptance
//   init_done               array cleared and usable
module unified_mem_responder #(
    parameter int AW             = 11,
    parameter int DW             = 32,
    parameter int DEPTH          = 2048,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] I_ADDR,
    input  logic          im_oen,
    output logic [DW-1:0] IR,
    input  logic [AW-1:0] D_ADDR,
    input  logic          dm_oen,
    input  logic          dm_wen,
    input  logic [DW-1:0] D_OUT,
    output logic [DW-1:0] D_IN,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          init_done
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] d_in_q, d_in_d;

    // Single array write port: clear, core write and preload are mutually
    // exclusive (core write wins over preload via ld_ready).
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    logic          i_ok, d_ok, ld_ok;
    logic [DW-1:0] i_rd, d_rd;

    assign i_ok  = {1'b0, I_ADDR}  < DEPTH_W;
    assign d_ok  = {1'b0, D_ADDR}  < DEPTH_W;
    assign ld_ok = {1'b0, ld_addr} < DEPTH_W;

    // Reads see the array before this edge's write lands (read-before-write).
    assign i_rd = i_ok ? mem[I_ADDR] : '0;
    assign d_rd = d_ok ? mem[D_ADDR] : '0;

    assign init_done = (state_q == S_RUN);
    assign ld_ready  = init_done & dm_wen;
    assign IR        = ir_q;
    assign D_IN      = d_in_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ir_d      = ir_q;
        d_in_d    = d_in_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;

        case (state_q)
            S_CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) state_d = S_RUN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!im_oen) ir_d = i_rd;

                if (!dm_oen) d_in_d = !dm_wen ? (d_ok ? D_OUT : '0) : d_rd;

                if (!dm_wen) begin
                    if (d_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = D_ADDR;
                        mem_wdata = D_OUT;
                    end
                end else if (ld_valid && ld_ready && ld_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = ld_addr;
                    mem_wdata = ld_data;
                end
            end
            default: state_d = S_CLEAR;
        endcase

        // Reset overrides everything, including any write or preload this cycle.
        if (!rst_n) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            ir_d    = '0;
            d_in_d  = '0;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ir_q    <= ir_d;
        d_in_q  <= d_in_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule
